// File: rtl/lfsr_gen.sv
`default_nettype none
// ============================================================================
// Module   : lfsr_gen
// Purpose  : Parametrised linear-feedback shift register with parallel load,
//            shift enable, selectable Fibonacci/Galois feedback and period
//            detection (length of the last completed cycle back to the value
//            captured at the last reset or load).
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Parameters
//   WIDTH   register width in bits (>= 2)
//   TAPS    feedback tap mask, bit i set -> stage i participates
//   GALOIS  0 = Fibonacci feedback, 1 = Galois feedback
//   SEED    state after reset
// Ports
//   clk      in   1      clock, rising edge
//   rst      in   1      synchronous active-high reset
//   L        in   1      parallel load strobe (priority over EN)
//   EN       in   1      shift enable, one step per cycle
//   R        in   WIDTH  parallel load value
//   Qout     out  WIDTH  current register state
//   bit_out  out  1      serial output, Qout[WIDTH-1]
//   wrap     out  1      one-cycle pulse when the state returns to start
//   period   out  WIDTH  length of the last completed cycle, in steps
// Optional feature
//   LFSR_LOCKUP_GUARD_EN : when defined, an enabled step from the all-zero
//                          state produces SEED instead of staying at zero.
// ============================================================================
module lfsr_gen #(
    parameter int               WIDTH  = 8,
    parameter logic [WIDTH-1:0] TAPS   = 8'hB8,
    parameter int               GALOIS = 0,
    parameter logic [WIDTH-1:0] SEED   = 8'h01
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             L,
    input  logic             EN,
    input  logic [WIDTH-1:0] R,
    output logic [WIDTH-1:0] Qout,
    output logic             bit_out,
    output logic             wrap,
    output logic [WIDTH-1:0] period
);

    logic [WIDTH-1:0] r_q;
    logic [WIDTH-1:0] r_start;
    logic [WIDTH-1:0] r_cnt;
    logic [WIDTH-1:0] r_period;
    logic             r_wrap;

    logic [WIDTH-1:0] w_shift;
    logic [WIDTH-1:0] w_next;
    logic [WIDTH-1:0] w_cnt_inc;
    logic             w_match;

    // Raw feedback step, selected at elaboration time.
    generate
        if (GALOIS != 0) begin : g_galois
            assign w_shift = {r_q[WIDTH-2:0], 1'b0} ^ ({WIDTH{r_q[WIDTH-1]}} & TAPS);
        end else begin : g_fibonacci
            logic w_fb;
            assign w_fb    = ^(r_q & TAPS);
            assign w_shift = {r_q[WIDTH-2:0], w_fb};
        end
    endgenerate

`ifdef LFSR_LOCKUP_GUARD_EN
    // Escape the all-zero lockup state by jumping to SEED; still a normal step.
    assign w_next = (r_q == '0) ? SEED : w_shift;
`else
    assign w_next = w_shift;
`endif

    assign w_match   = (w_next == r_start);
    // Truncation to WIDTH bits is intended: a maximal 2^WIDTH-1 period fits.
    assign w_cnt_inc = r_cnt + 1'b1;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_q      <= SEED;
            r_start  <= SEED;
            r_cnt    <= '0;
            r_period <= '0;
            r_wrap   <= 1'b0;
        end else if (L) begin
            r_q      <= R;
            r_start  <= R;
            r_cnt    <= '0;
            r_period <= '0;
            r_wrap   <= 1'b0;
        end else if (EN) begin
            r_q <= w_next;
            if (w_match) begin
                r_cnt    <= '0;
                r_period <= w_cnt_inc;
                r_wrap   <= 1'b1;
            end else begin
                r_cnt  <= w_cnt_inc;
                r_wrap <= 1'b0;
            end
        end else begin
            // Hold: state, counter and period keep their values.
            r_wrap <= 1'b0;
        end
    end

    assign Qout    = r_q;
    assign bit_out = r_q[WIDTH-1];
    assign wrap    = r_wrap;
    assign period  = r_period;

endmodule
`default_nettype wire

// File: tb/tb_lfsr_gen.sv
`default_nettype none
// ============================================================================
// Module   : tb_lfsr_gen
// Purpose  : Directed self-checking bench for lfsr_gen: default 8-bit
//            Fibonacci instance and a 3-bit Galois instance.
// Revision : 1.0 - initial release
// ============================================================================
module tb_lfsr_gen;

    logic       clk;
    logic       rst, L, EN;
    logic [7:0] R;
    logic [7:0] Qout, period;
    logic       bit_out, wrap;

    logic       rst3, L3, EN3;
    logic [2:0] R3;
    logic [2:0] Qout3, period3;
    logic       bit_out3, wrap3;

    int n_vec;
    int n_err;

    lfsr_gen dut (
        .clk     (clk),
        .rst     (rst),
        .L       (L),
        .EN      (EN),
        .R       (R),
        .Qout    (Qout),
        .bit_out (bit_out),
        .wrap    (wrap),
        .period  (period)
    );

    lfsr_gen #(
        .WIDTH  (3),
        .TAPS   (3'b101),
        .GALOIS (1),
        .SEED   (3'b001)
    ) dut3 (
        .clk     (clk),
        .rst     (rst3),
        .L       (L3),
        .EN      (EN3),
        .R       (R3),
        .Qout    (Qout3),
        .bit_out (bit_out3),
        .wrap    (wrap3),
        .period  (period3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk_vec(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_vec++;
        if (obs !== exp_v) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp_v);
        end
    endtask

    // Advance one clock and sample just after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    logic [2:0] gal_seq [7];
    int         n_wrap;

    initial begin
        n_vec = 0;
        n_err = 0;
        gal_seq = '{3'b010, 3'b100, 3'b101, 3'b111, 3'b011, 3'b110, 3'b001};
        rst = 1'b1; L = 1'b0; EN = 1'b0; R = 8'h00;
        rst3 = 1'b1; L3 = 1'b0; EN3 = 1'b0; R3 = 3'b000;
        tick();
        rst = 1'b0; rst3 = 1'b0;

        // ---- Reset state ----
        chk_vec("rst_qout",   Qout,    8'h01);
        chk_vec("rst_period", period,  8'h00);
        chk_vec("rst_wrap",   wrap,    1'b0);
        chk_vec("rst_bitout", bit_out, 1'b0);
        chk_vec("g3_rst_qout", Qout3,  3'b001);

        // ---- 3-bit Galois sequence ----
        EN3 = 1'b1;
        for (int i = 0; i < 7; i++) begin
            tick();
            chk_vec($sformatf("g3_q%0d", i), Qout3, gal_seq[i]);
            chk_vec($sformatf("g3_w%0d", i), wrap3, (i == 6) ? 1'b1 : 1'b0);
            chk_vec($sformatf("g3_b%0d", i), bit_out3, gal_seq[i][2]);
        end
        chk_vec("g3_period", period3, 3'd7);
        EN3 = 1'b0;

        // ---- Full 255-step period, default Fibonacci ----
        EN = 1'b1;
        n_wrap = 0;
        for (int i = 0; i < 254; i++) begin
            tick();
            if (wrap) n_wrap++;
        end
        chk_vec("early_wrap", n_wrap, 0);
        tick();
        chk_vec("p255_qout",   Qout,   8'h01);
        chk_vec("p255_wrap",   wrap,   1'b1);
        chk_vec("p255_period", period, 8'd255);
        tick();
        chk_vec("post_qout",   Qout,   8'h02);
        chk_vec("post_wrap",   wrap,   1'b0);
        chk_vec("post_period", period, 8'd255);

        // ---- Hold for 5 cycles ----
        EN = 1'b0;
        for (int i = 0; i < 5; i++) tick();
        chk_vec("hold_qout",   Qout,   8'h02);
        chk_vec("hold_period", period, 8'd255);
        chk_vec("hold_wrap",   wrap,   1'b0);

        // Step count must resume: 253 more steps without wrap, then wrap.
        EN = 1'b1;
        tick();
        chk_vec("resume_qout", Qout, 8'h04);
        n_wrap = 0;
        for (int i = 0; i < 252; i++) begin
            tick();
            if (wrap) n_wrap++;
        end
        chk_vec("resume_nowrap", n_wrap, 0);
        tick();
        chk_vec("resume_wrap",   wrap,   1'b1);
        chk_vec("resume_qout2",  Qout,   8'h01);
        chk_vec("resume_period", period, 8'd255);

        // ---- Reset mid-run ----
        tick(); tick(); tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk_vec("midrst_qout",   Qout,   8'h01);
        chk_vec("midrst_period", period, 8'h00);
        chk_vec("midrst_wrap",   wrap,   1'b0);

        // ---- Load with EN in the same cycle ----
        L = 1'b1; R = 8'h5A;
        tick();
        L = 1'b0;
        chk_vec("load_qout",   Qout,   8'h5A);
        chk_vec("load_period", period, 8'h00);
        tick();
        chk_vec("load_step",   Qout,    8'hB4);
        chk_vec("load_bitout", bit_out, 1'b1);
        chk_vec("load_wrap",   wrap,    1'b0);

        // ---- Load all-zero ----
        L = 1'b1; R = 8'h00;
        tick();
        L = 1'b0;
        chk_vec("zero_load", Qout, 8'h00);
        tick();
`ifdef LFSR_LOCKUP_GUARD_EN
        chk_vec("zero_guard_qout", Qout, 8'h01);
        chk_vec("zero_guard_wrap", wrap, 1'b0);
`else
        chk_vec("zero_qout1",   Qout,   8'h00);
        chk_vec("zero_wrap1",   wrap,   1'b1);
        chk_vec("zero_period1", period, 8'd1);
        tick();
        chk_vec("zero_qout2",   Qout,   8'h00);
        chk_vec("zero_wrap2",   wrap,   1'b1);
        chk_vec("zero_period2", period, 8'd1);
`endif
        EN = 1'b0;
        tick();
        chk_vec("final_hold_wrap", wrap, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/lfsr_gen.md
# lfsr_gen

Parametrised linear-feedback shift register with parallel load, shift enable, selectable Fibonacci/Galois feedback and period detection. It generalises the fixed 3-bit load/shift register with XOR feedback into a configurable pseudo-random sequence source for test-pattern, scrambler and counter-replacement uses. It sits directly on the system clock, with load data from surrounding datapath logic. With `WIDTH=3`, `GALOIS=1`, `TAPS=3'b101` it reproduces the predecessor's sequence exactly.

## Interface
- `WIDTH`, 8: register width in bits, at least 2.
- `TAPS`, 8'hB8: feedback tap mask, `WIDTH` bits; bit i set means stage i participates.
- `GALOIS`, 0: 0 selects Fibonacci feedback, 1 selects Galois feedback.
- `SEED`, 8'h01: state after reset, `WIDTH` bits.

- `clk`  in  1  clock; all state updates on its rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `L`  in  1  parallel load strobe.
- `EN`  in  1  shift enable, one step per cycle.
- `R`  in  WIDTH  parallel load value.
- `Qout`  out  WIDTH  current register state.
- `bit_out`  out  1  serial output, combinational, equals `Qout[WIDTH-1]`.
- `wrap`  out  1  registered one-cycle pulse: state has returned to the start value.
- `period`  out  WIDTH  length of the last completed cycle, in steps.

## Operation
- Per-edge priority: `rst` first, then `L`, then `EN`; otherwise hold.
- Reset sets `Qout=SEED`, `start=SEED`, `cnt=0`, `wrap=0`, `period=0`.
- Load sets `Qout=R`, `start=R`, `cnt=0`, `wrap=0` and `period=0`. `EN` is ignored in a load cycle.
- Fibonacci step: `fb = ^(Qout & TAPS)`; next state is `{Qout[WIDTH-2:0], fb}`.
- Galois step: next state is `{Qout[WIDTH-2:0],1'b0} ^ ({WIDTH{Qout[WIDTH-1]}} & TAPS)`.
- `start` is an internal register holding the value captured at the last reset or load.
- `cnt` is an internal WIDTH-bit step counter.
- On each step, the block compares the next state with `start`:
  - Equal: `cnt` goes to 0, `period` takes `cnt+1`, and `wrap` goes to 1 on the following cycle.
  - Not equal: `cnt` increments and `wrap` goes to 0.
- `wrap` is 0 in every cycle that is not a matching step, including hold cycles.
- Width rule: `cnt+1` is truncated to WIDTH bits. A maximal period of 2^WIDTH−1 fits exactly.
- All-zero state without the lockup guard: the state stays 0. Every enabled step then matches `start=0`, so `wrap` pulses each step and `period=1`.

## Timing
- Latency of load and step: 1 cycle. `Qout` updates on the same edge that samples `L`/`EN`.
- `wrap=1` in exactly the cycle where `Qout==start` again after a step; `period` is valid in that same cycle and holds until the next wrap, load or reset.
- `bit_out` is combinational from `Qout`, with no added latency.
- Reset or load in the middle of a sequence discards the progress made so far; counting restarts from the new value on the next step.
- `EN` held high gives one step per cycle. With `EN` low, `Qout`, `cnt` and `period` hold.

## Configuration
- `LFSR_LOCKUP_GUARD_EN` defined:
  - An enabled step taken from `Qout==0` produces `SEED` instead of 0.
  - This step is counted as a normal step (compared against `start`, `cnt` updated).
  - Loading 0 is still accepted; recovery happens on the first enabled step after it.
- `LFSR_LOCKUP_GUARD_EN` not defined: no special case; the all-zero behaviour is as stated under Operation.

## Test plan
- Reset with defaults, then hold `EN=1`:
  - after reset, `Qout=8'h01` and `period=0`;
  - after 255 steps, `Qout=8'h01`, `wrap=1` for one cycle and `period=8'd255`;
  - no `wrap` pulse appears earlier.
- `WIDTH=3`, `GALOIS=1`, `TAPS=3'b101`, `SEED=3'b001`, `EN=1`:
  - `Qout` sequence is 001, 010, 100, 101, 111, 011, 110, 001;
  - `wrap` pulses with the second 001 and `period=7`.
- Load `R=8'h5A` with `L=1`, `EN=1` in the same cycle → `Qout=8'h5A` next cycle and no step taken. The next step from 8'h5A is 8'hB4.
- `EN` low for 5 cycles mid-run → `Qout`, `period` and the step count are unchanged. Then assert `rst` mid-run → `Qout=SEED` and `period=0`.
- Load `R=0`, then `EN=1`:
  - without `LFSR_LOCKUP_GUARD_EN`: `Qout` stays 0, `wrap` pulses every cycle, `period=1`;
  - with the macro: `Qout=SEED` after the first step.
